reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/riscv_pkg.sv | 15 +
 rtl/reg_file_if.sv | 28 ++
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/reg_file.sv | 82 ++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-register definitions: data width, register address type and the x0 constant.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True for an address that may hold state: not x0 and below the implemented register count.
    function automatic logic addr_writable(input reg_addr_t addr, input int num_regs);
        return (addr != REG_ZERO) && (int'(addr) < num_regs);
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bundle of the register-file read, writeback and reservation signals for bench/core hookup.
interface reg_file_if;
    import riscv_pkg::*;

    logic             rd_we;
    reg_addr_t        rd_addr;
    logic [XLEN-1:0]  rd_data;
    reg_addr_t        rs1_addr;
    reg_addr_t        rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rsv_valid;
    reg_addr_t        rsv_addr;
    logic             rsv_ready;

    modport master (
        output rd_we, rd_addr, rd_data, rs1_addr, rs2_addr, rsv_valid, rsv_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ready
    );

    modport slave (
        input  rd_we, rd_addr, rd_data, rs1_addr, rs2_addr, rsv_valid, rsv_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ready
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by accepted reservations, cleared by writebacks; reservation wins on a tie.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clr_en_i,
    input  reg_addr_t clr_addr_i,
    input  logic      set_en_i,
    input  reg_addr_t set_addr_i,
    input  reg_addr_t lk1_addr_i,
    input  reg_addr_t lk2_addr_i,
    output logic      busy1_o,
    output logic      busy2_o,
    output logic      ready_o
);

    logic [NUM_REGS-1:0] r_busy;
    logic [31:0]         w_busy_ext;
    logic                w_set;
    logic                w_clr;

    // Zero-extend to the full 5-bit address space so out-of-range lookups read as not busy.
    always_comb begin
        w_busy_ext                 = '0;
        w_busy_ext[NUM_REGS-1:0]   = r_busy;
    end

    assign busy1_o = w_busy_ext[lk1_addr_i];
    assign busy2_o = w_busy_ext[lk2_addr_i];
    assign ready_o = ~w_busy_ext[set_addr_i];

    assign w_set = set_en_i && ready_o && addr_writable(set_addr_i, NUM_REGS);
    assign w_clr = clr_en_i && addr_writable(clr_addr_i, NUM_REGS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_set && (int'(set_addr_i) == i)) begin
                    r_busy[i] <= 1'b1;
                end else if (w_clr && (int'(clr_addr_i) == i)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Integer register file with busy scoreboard; define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  reg_addr_t       rs1_addr_i,
    input  reg_addr_t       rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    input  logic            rd_we_i,
    input  reg_addr_t       rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            rsv_valid_i,
    input  reg_addr_t       rsv_addr_i,
    output logic            rsv_ready_o
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_we;
    logic [XLEN-1:0] w_rs1_stored;
    logic [XLEN-1:0] w_rs2_stored;
    logic            w_sb_busy1;
    logic            w_sb_busy2;

    assign w_we = rd_we_i && addr_writable(rd_addr_i, NUM_REGS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[rd_addr_i[IDX_W-1:0]] <= rd_data_i;
        end
    end

    // x0 and unimplemented addresses never index the array; they read as zero.
    assign w_rs1_stored = addr_writable(rs1_addr_i, NUM_REGS) ? r_regs[rs1_addr_i[IDX_W-1:0]] : '0;
    assign w_rs2_stored = addr_writable(rs2_addr_i, NUM_REGS) ? r_regs[rs2_addr_i[IDX_W-1:0]] : '0;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_en_i   (rd_we_i),
        .clr_addr_i (rd_addr_i),
        .set_en_i   (rsv_valid_i),
        .set_addr_i (rsv_addr_i),
        .lk1_addr_i (rs1_addr_i),
        .lk2_addr_i (rs2_addr_i),
        .busy1_o    (w_sb_busy1),
        .busy2_o    (w_sb_busy2),
        .ready_o    (rsv_ready_o)
    );

`ifdef REGFILE_BYPASS_EN
    logic w_rs1_fwd;
    logic w_rs2_fwd;

    // Forwarding is gated by reset so outputs stay zero while rst_ni is low.
    assign w_rs1_fwd  = rst_ni && w_we && (rd_addr_i == rs1_addr_i);
    assign w_rs2_fwd  = rst_ni && w_we && (rd_addr_i == rs2_addr_i);
    assign rs1_data_o = w_rs1_fwd ? rd_data_i : w_rs1_stored;
    assign rs2_data_o = w_rs2_fwd ? rd_data_i : w_rs2_stored;
    assign rs1_busy_o = w_sb_busy1 && !w_rs1_fwd;
    assign rs2_busy_o = w_sb_busy2 && !w_rs2_fwd;
`else
    assign rs1_data_o = w_rs1_stored;
    assign rs2_data_o = w_rs2_stored;
    assign rs1_busy_o = w_sb_busy1;
    assign rs2_busy_o = w_sb_busy2;
`endif

endmodule
